// File: rtl/mux32_rr_arbiter_pkg.sv
// Shared types for the two-requester 32-bit round-robin arbiter.
// State encoding and source identifiers.
package mux32_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Owner state for a given source.
  function automatic state_t own_state(input logic src);
    return (src == SRC_B) ? ST_OWN_B : ST_OWN_A;
  endfunction

endpackage

// File: rtl/mux32_rr_arbiter_mux.sv
// 2:1 32-bit data mux built from AND/OR terms.
// sel=0 passes a, sel=1 passes b.
module mux_2to1_32bit_gatelevel (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] y
);

  logic [31:0] sel_v;

  assign sel_v = {32{sel}};
  assign y     = (a & ~sel_v) | (b & sel_v);

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin owner arbiter sharing one 32-bit path between A and B.
// Bounded bursts, single registered output slot.
module mux32_rr_arbiter
  import mux32_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_src,
  input  logic        out_ready,
  output logic        grant_sel
);

  state_t             state;
  logic               prio;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mux_y;
  logic               load;
  logic               own_a;
  logic               own_b;
  logic               xfer;
  logic               other_valid;
  logic               other_src;
  logic               burst_end;

  assign own_a       = (state == ST_OWN_A);
  assign own_b       = (state == ST_OWN_B);
  assign load        = ~out_valid | out_ready;
  assign grant_sel   = own_b;
  assign a_ready     = own_a & load & ~rst;
  assign b_ready     = own_b & load & ~rst;
  assign xfer        = (a_valid & a_ready) | (b_valid & b_ready);
  assign other_valid = own_b ? a_valid : b_valid;
  assign other_src   = own_b ? SRC_A : SRC_B;
  assign burst_end   = (cnt == CNT_W'(MAX_BURST - 1));

  mux_2to1_32bit_gatelevel u_mux (
    .a   (a_data),
    .b   (b_data),
    .sel (grant_sel),
    .y   (mux_y)
  );

  // Ownership FSM, burst counter, priority pointer and output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      prio      <= SRC_A;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC_A;
    end else begin
      if (load & ~xfer)
        out_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (a_valid & (~b_valid | (prio == SRC_A)))
            state <= ST_OWN_A;
          else if (b_valid)
            state <= ST_OWN_B;
        end
        ST_OWN_A, ST_OWN_B: begin
          if (load) begin
            if (xfer) begin
              out_data  <= mux_y;
              out_src   <= own_b ? SRC_B : SRC_A;
              out_valid <= 1'b1;
              if (burst_end) begin
                cnt  <= '0;
                prio <= other_src;
                if (other_valid)
                  state <= own_state(other_src);
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              cnt   <= '0;
              prio  <= other_src;
              state <= other_valid ? own_state(other_src)
                                   : ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// Directed vector bench for mux32_rr_arbiter.
// Table of per-cycle stimulus plus a round-robin stream sequence.
module tb_mux32_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_ready = 1'b1;
  logic        grant_sel;

  localparam logic [31:0] AH = 32'hAAAA_0000;
  localparam logic [31:0] BH = 32'hBBBB_0000;

  always #5 clk = ~clk;

  mux32_rr_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .grant_sel (grant_sel)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [31:0] ad;
    logic        bv;
    logic [31:0] bd;
    logic        ordy;
    logic        ar;
    logic        br;
    logic        gs;
    logic        ov;
    logic [31:0] od;
    logic        os;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   failed = 0;

  function automatic void add(
    input logic r, input logic av, input logic [31:0] ad,
    input logic bv, input logic [31:0] bd, input logic ordy,
    input logic ar, input logic br, input logic gs,
    input logic ov, input logic [31:0] od, input logic os);
    vec_t v;
    v.rst = r;   v.av = av; v.ad = ad; v.bv = bv;
    v.bd = bd;   v.ordy = ordy;
    v.ar = ar;   v.br = br; v.gs = gs;
    v.ov = ov;   v.od = od; v.os = os;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s row %0d: got %h expected %h",
               nm, row, act, exp);
    end
  endtask

  int na;
  int nb;
  int got;
  logic acc_a;
  logic acc_b;

  initial begin
    // reset: both valids high, outputs and readies low
    add(1,1,32'h11,1,32'h22,1, 0,0,0, 0,0,0);
    add(1,1,32'h11,1,32'h22,1, 0,0,0, 0,0,0);
    // only A streams 6 beats across a burst boundary
    add(0,1,1,0,0,1, 0,0,0, 0,0,0);
    add(0,1,1,0,0,1, 1,0,0, 1,1,0);
    add(0,1,2,0,0,1, 1,0,0, 1,2,0);
    add(0,1,3,0,0,1, 1,0,0, 1,3,0);
    add(0,1,4,0,0,1, 1,0,0, 1,4,0);
    add(0,1,5,0,0,1, 1,0,0, 1,5,0);
    add(0,1,6,0,0,1, 1,0,0, 1,6,0);
    add(0,0,0,0,0,1, 1,0,0, 0,0,0);
    add(1,0,0,0,0,1, 0,0,0, 0,0,0);
    // both valid: 4 A beats then 4 B beats then A
    add(0,1,AH|1,1,BH|1,1, 0,0,0, 0,0,0);
    add(0,1,AH|1,1,BH|1,1, 1,0,0, 1,AH|1,0);
    add(0,1,AH|2,1,BH|1,1, 1,0,0, 1,AH|2,0);
    add(0,1,AH|3,1,BH|1,1, 1,0,0, 1,AH|3,0);
    add(0,1,AH|4,1,BH|1,1, 1,0,0, 1,AH|4,0);
    add(0,1,AH|5,1,BH|1,1, 0,1,1, 1,BH|1,1);
    add(0,1,AH|5,1,BH|2,1, 0,1,1, 1,BH|2,1);
    add(0,1,AH|5,1,BH|3,1, 0,1,1, 1,BH|3,1);
    add(0,1,AH|5,1,BH|4,1, 0,1,1, 1,BH|4,1);
    add(0,1,AH|5,1,BH|5,1, 1,0,0, 1,AH|5,0);
    // backpressure mid-burst, counter must hold
    add(0,1,AH|6,0,0,1, 1,0,0, 1,AH|6,0);
    add(0,1,AH|7,0,0,0, 0,0,0, 1,AH|6,0);
    add(0,1,AH|7,0,0,0, 0,0,0, 1,AH|6,0);
    add(0,1,AH|7,0,0,0, 0,0,0, 1,AH|6,0);
    add(0,1,AH|7,0,0,1, 1,0,0, 1,AH|7,0);
    add(0,1,AH|8,1,BH|5,1, 1,0,0, 1,AH|8,0);
    add(0,1,AH|9,1,BH|5,1, 0,1,1, 1,BH|5,1);
    // owner drops valid while the other side waits
    add(0,1,AH|9,0,0,1, 0,1,1, 0,0,0);
    add(0,1,AH|9,0,0,1, 1,0,0, 1,AH|9,0);
    add(0,1,AH|10,0,0,1, 1,0,0, 1,AH|10,0);
    add(0,0,0,1,BH|6,1, 1,0,0, 0,0,0);
    add(0,0,0,1,BH|6,1, 0,1,1, 1,BH|6,1);
    // reset mid-burst with a full slot, A wins next
    add(1,1,AH|11,1,BH|7,1, 0,0,1, 0,0,0);
    add(0,1,AH|11,1,BH|7,1, 0,0,0, 0,0,0);
    add(0,1,AH|11,1,BH|7,1, 1,0,0, 1,AH|11,0);

    rst = 1'b1;
    @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      a_valid   = vecs[i].av;
      a_data    = vecs[i].ad;
      b_valid   = vecs[i].bv;
      b_data    = vecs[i].bd;
      out_ready = vecs[i].ordy;
      #1;
      chk("a_ready", i, 32'(a_ready), 32'(vecs[i].ar));
      chk("b_ready", i, 32'(b_ready), 32'(vecs[i].br));
      chk("grant_sel", i, 32'(grant_sel), 32'(vecs[i].gs));
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
      if (vecs[i].ov || vecs[i].rst) begin
        chk("out_data", i, out_data, vecs[i].od);
        chk("out_src", i, 32'(out_src), 32'(vecs[i].os));
      end
    end

    // continuous round-robin stream: 4 A, 4 B, 4 A, 4 B
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    na = 1;
    nb = 1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      @(negedge clk);
      rst       = 1'b0;
      a_valid   = 1'b1;
      b_valid   = 1'b1;
      a_data    = AH | 32'(na);
      b_data    = BH | 32'(nb);
      out_ready = 1'b1;
      #1;
      acc_a = a_ready;
      acc_b = b_ready;
      chk("one_ready", 100 + cyc, 32'(acc_a & acc_b), 32'd0);
      @(posedge clk);
      #1;
      if (acc_a) na++;
      if (acc_b) nb++;
      if (out_valid) begin
        logic        es;
        logic [31:0] ed;
        es = ((got % 8) >= 4);
        ed = (es ? BH : AH)
           | 32'((got / 8) * 4 + (got % 4) + 1);
        chk("rr_src", 100 + cyc, 32'(out_src), 32'(es));
        chk("rr_data", 100 + cyc, out_data, ed);
        got++;
      end
    end
    chk("rr_beats", 200, 32'(got), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
